// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared constants, FSM state codes and event layout for the
//             PS/2 set-2 scan decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix and device-reply bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_ERR1  = 8'hFF;
    localparam logic [7:0] PS2_BATF0 = 8'hFC;
    localparam logic [7:0] PS2_BATF1 = 8'hFD;
    localparam logic [7:0] PS2_RESND = 8'hFE;

    // Modifier scan codes; right ctrl/alt share the left code behind E0
    localparam logic [7:0] KEY_SHIFT_L = 8'h12;
    localparam logic [7:0] KEY_SHIFT_R = 8'h59;
    localparam logic [7:0] KEY_CTRL    = 8'h14;
    localparam logic [7:0] KEY_ALT     = 8'h11;

    // Bytes still to swallow after the E1 that opens the pause sequence
    localparam logic [2:0] PS2_SKIP_LEN = 3'd7;

    // Prefix FSM state codes
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_E0   = 3'd1;
    localparam logic [2:0] ST_F0   = 3'd2;
    localparam logic [2:0] ST_E0F0 = 3'd3;
    localparam logic [2:0] ST_SKIP = 3'd4;

    // Modifier register bit positions
    localparam int MOD_LSHIFT = 0;
    localparam int MOD_RSHIFT = 1;
    localparam int MOD_LCTRL  = 2;
    localparam int MOD_RCTRL  = 3;
    localparam int MOD_LALT   = 4;
    localparam int MOD_RALT   = 5;

    // Event word field offsets
    localparam int EV_CODE_LSB  = 0;
    localparam int EV_SHIFT_BIT = 8;
    localparam int EV_CTRL_BIT  = 9;
    localparam int EV_ALT_BIT   = 10;
    localparam int EV_BRK_BIT   = 16;
    localparam int EV_EXT_BIT   = 17;
    localparam int EV_DEV_LSB   = 24;

    function automatic logic is_reply(input logic [7:0] b);
        case (b)
            PS2_ERR0, PS2_BAT, PS2_ECHO, PS2_ACK,
            PS2_BATF0, PS2_BATF1, PS2_RESND, PS2_ERR1: is_reply = 1'b1;
            default:                                   is_reply = 1'b0;
        endcase
    endfunction

    // E0-prefixed shift codes are keyboard-generated noise around nav keys
    function automatic logic is_fake_shift(input logic [7:0] b);
        is_fake_shift = (b == KEY_SHIFT_L) || (b == KEY_SHIFT_R);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : event_fifo
//  Brief    : First-word-fall-through event FIFO with a registered head word
//             that holds its last value when the FIFO drains.
//  Revision : 1.0 - initial release
// ============================================================================
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     empty,
    output logic                     full
);

    localparam int                c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic [c_aw-1:0]  w_rd_ptr_inc;
    logic             w_pop;
    logic             w_push_ok;

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_depth);
    assign w_pop        = pop && !empty;
    // A pop frees the slot a full-FIFO push needs in the same cycle
    assign w_push_ok    = push && (!full || w_pop);
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_comb begin
        count_next = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   count_next = r_count + 1'b1;
            2'b01:   count_next = r_count - 1'b1;
            default: count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_count <= count_next;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            // Head mirrors mem[rd_ptr]; bypass when that slot is written this cycle
            if (w_push_ok && empty) begin
                r_head <= push_data;
            end else if (w_pop && (r_count > 1)) begin
                r_head <= r_mem[w_rd_ptr_inc];
            end else if (w_pop && w_push_ok) begin
                r_head <= push_data;
            end
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_decoder
//  Brief    : PS/2 set-2 byte stream to key-event decoder with modifier
//             tracking, pause/reply filtering and an FWFT event queue.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter logic [7:0] DEV_ID  = 8'd2,
    parameter int         TIMEOUT = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   rd,
    input  logic                   clr_ovf,
    output logic [31:0]            out,
    output logic                   out_valid,
    output logic                   irq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int                  c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [2:0]         r_skip_cnt;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [5:0]         r_mods;
    logic               r_overflow;
    logic               r_irq;

    logic [2:0]         w_state_next;
    logic [2:0]         w_skip_next;
    logic [c_tmo_w-1:0] w_tmo_next;
    logic               w_emit;
    logic               w_ext;
    logic               w_brk;
    logic [5:0]         w_mods_next;
    logic [31:0]        w_event;
    logic [$clog2(DEPTH):0] w_count_next;
    logic               w_empty;
    logic               w_full;
    logic               w_drop;

    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip_cnt;
        w_tmo_next   = r_tmo_cnt;
        w_emit       = 1'b0;
        w_ext        = 1'b0;
        w_brk        = 1'b0;
        if (in_valid) begin
            w_tmo_next = '0;
            case (r_state)
                ST_IDLE: begin
                    if (in_data == PS2_EXT) begin
                        w_state_next = ST_E0;
                    end else if (in_data == PS2_BRK) begin
                        w_state_next = ST_F0;
                    end else if (in_data == PS2_PAUSE) begin
                        w_state_next = ST_SKIP;
                        w_skip_next  = PS2_SKIP_LEN;
                    end else begin
                        w_emit = !is_reply(in_data);
                    end
                end
                ST_E0: begin
                    if (in_data == PS2_BRK) begin
                        w_state_next = ST_E0F0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_emit       = !is_fake_shift(in_data);
                        w_ext        = 1'b1;
                    end
                end
                ST_F0: begin
                    w_state_next = ST_IDLE;
                    w_emit       = 1'b1;
                    w_brk        = 1'b1;
                end
                ST_E0F0: begin
                    w_state_next = ST_IDLE;
                    w_emit       = !is_fake_shift(in_data);
                    w_ext        = 1'b1;
                    w_brk        = 1'b1;
                end
                ST_SKIP: begin
                    w_skip_next = r_skip_cnt - 1'b1;
                    if (r_skip_cnt == 3'd1) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            // A stalled prefix is abandoned silently
            if (r_tmo_cnt >= c_tmo_last) begin
                w_state_next = ST_IDLE;
                w_tmo_next   = '0;
            end else begin
                w_tmo_next = r_tmo_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_mods_next = r_mods;
        if (w_emit) begin
            case ({w_ext, in_data})
                {1'b0, KEY_SHIFT_L}: w_mods_next[MOD_LSHIFT] = !w_brk;
                {1'b0, KEY_SHIFT_R}: w_mods_next[MOD_RSHIFT] = !w_brk;
                {1'b0, KEY_CTRL}:    w_mods_next[MOD_LCTRL]  = !w_brk;
                {1'b1, KEY_CTRL}:    w_mods_next[MOD_RCTRL]  = !w_brk;
                {1'b0, KEY_ALT}:     w_mods_next[MOD_LALT]   = !w_brk;
                {1'b1, KEY_ALT}:     w_mods_next[MOD_RALT]   = !w_brk;
                default:             w_mods_next = r_mods;
            endcase
        end
    end

    always_comb begin
        w_event                        = '0;
        w_event[EV_DEV_LSB +: 8]       = DEV_ID;
        w_event[EV_EXT_BIT]            = w_ext;
        w_event[EV_BRK_BIT]            = w_brk;
        w_event[EV_ALT_BIT]            = w_mods_next[MOD_LALT]   | w_mods_next[MOD_RALT];
        w_event[EV_CTRL_BIT]           = w_mods_next[MOD_LCTRL]  | w_mods_next[MOD_RCTRL];
        w_event[EV_SHIFT_BIT]          = w_mods_next[MOD_LSHIFT] | w_mods_next[MOD_RSHIFT];
        w_event[EV_CODE_LSB +: 8]      = in_data;
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_emit),
        .push_data  (w_event),
        .pop        (rd),
        .head       (out),
        .count      (count),
        .count_next (w_count_next),
        .empty      (w_empty),
        .full       (w_full)
    );

    // rd on a full FIFO always pops, so only a push without rd is lost
    assign w_drop = w_emit && w_full && !rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_mods     <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_skip_cnt <= w_skip_next;
            r_tmo_cnt  <= w_tmo_next;
            r_mods     <= w_mods_next;
            r_irq      <= (w_count_next != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = !w_empty;
    assign irq       = r_irq;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_scan_decoder
//  Brief    : Directed self-checking bench for ps2_scan_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_decoder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        rd;
    logic        clr_ovf;
    logic [31:0] out;
    logic        out_valid;
    logic        irq;
    logic [3:0]  count;
    logic        overflow;

    int vectors    = 0;
    int miscompares = 0;

    ps2_scan_decoder #(
        .DEPTH   (DEPTH),
        .DEV_ID  (8'd2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .rd        (rd),
        .clr_ovf   (clr_ovf),
        .out       (out),
        .out_valid (out_valid),
        .irq       (irq),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // All stimulus tasks start and end on a falling edge
    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++; if (out !== 32'h0) begin miscompares++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
        vectors++; if ({out_valid, irq, overflow} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {out_valid, irq, overflow}); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        vectors++; if (out !== 32'h0200001C) begin miscompares++; $display("FAIL mb_make got=%h exp=%h", out, 32'h0200001C); end
        vectors++; if ({out_valid, irq} !== 2'b11) begin miscompares++; $display("FAIL mb_valid_irq got=%b exp=11", {out_valid, irq}); end
        send_byte(8'hF0); send_byte(8'h1C);
        vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL mb_count got=%0d exp=2", count); end
        pop_one();
        vectors++; if (out !== 32'h0201001C) begin miscompares++; $display("FAIL mb_break got=%h exp=%h", out, 32'h0201001C); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL mb_irq_held got=%b exp=1", irq); end
        pop_one();
        vectors++; if ({out_valid, irq} !== 2'b00) begin miscompares++; $display("FAIL mb_drained got=%b exp=00", {out_valid, irq}); end
        vectors++; if (out !== 32'h0201001C) begin miscompares++; $display("FAIL mb_hold_last got=%h exp=%h", out, 32'h0201001C); end
    endtask

    task automatic test_extended();
        send_byte(8'hE0); send_byte(8'h75);
        vectors++; if (out !== 32'h02020075) begin miscompares++; $display("FAIL ext_make got=%h exp=%h", out, 32'h02020075); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        pop_one();
        vectors++; if (out !== 32'h02030075) begin miscompares++; $display("FAIL ext_break got=%h exp=%h", out, 32'h02030075); end
        pop_one();
    endtask

    task automatic test_modifiers();
        send_byte(8'h12);
        vectors++; if (out !== 32'h02000112) begin miscompares++; $display("FAIL mod_lshift_make got=%h exp=%h", out, 32'h02000112); end
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);
        pop_one();
        vectors++; if (out !== 32'h0200011C) begin miscompares++; $display("FAIL mod_shifted_key got=%h exp=%h", out, 32'h0200011C); end
        pop_one();
        vectors++; if (out !== 32'h02010012) begin miscompares++; $display("FAIL mod_shift_release got=%h exp=%h", out, 32'h02010012); end
        pop_one();
        send_byte(8'hE0); send_byte(8'h12);
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL mod_fake_shift got=%0d exp=0", count); end
        send_byte(8'hE0); send_byte(8'h14);
        vectors++; if (out !== 32'h02020214) begin miscompares++; $display("FAIL mod_rctrl got=%h exp=%h", out, 32'h02020214); end
        send_byte(8'h11);
        pop_one();
        vectors++; if (out !== 32'h02000611) begin miscompares++; $display("FAIL mod_lalt_ctrl got=%h exp=%h", out, 32'h02000611); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        pop_one();
        vectors++; if (out !== 32'h02030414) begin miscompares++; $display("FAIL mod_rctrl_rel got=%h exp=%h", out, 32'h02030414); end
        send_byte(8'hF0); send_byte(8'h11);
        pop_one();
        vectors++; if (out !== 32'h02010011) begin miscompares++; $display("FAIL mod_alt_rel got=%h exp=%h", out, 32'h02010011); end
        pop_one();
    endtask

    task automatic test_pause_and_replies();
        logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'hAA};
        for (int i = 0; i < 10; i++) send_byte(seq[i]);
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL pause_silent got=%0d exp=0", count); end
        send_byte(8'h29);
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL pause_count got=%0d exp=1", count); end
        vectors++; if (out !== 32'h02000029) begin miscompares++; $display("FAIL pause_next got=%h exp=%h", out, 32'h02000029); end
        pop_one();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count got=%0d exp=8", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        vectors++; if (out !== 32'h02000001) begin miscompares++; $display("FAIL ovf_head got=%h exp=%h", out, 32'h02000001); end
        clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        clr_ovf = 1'b1; send_byte(8'h0B); clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
        rd = 1'b1; send_byte(8'h0A); rd = 1'b0;
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_pushpop_count got=%0d exp=8", count); end
        vectors++; if (out !== 32'h02000002) begin miscompares++; $display("FAIL full_pushpop_head got=%h exp=%h", out, 32'h02000002); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 7; i++) pop_one();
        vectors++; if (out !== 32'h0200000A) begin miscompares++; $display("FAIL wrap_tail got=%h exp=%h", out, 32'h0200000A); end
        pop_one();
        rd = 1'b1; send_byte(8'h33); rd = 1'b0;
        vectors++; if ({count, out} !== {4'd1, 32'h02000033}) begin miscompares++; $display("FAIL empty_pushpop got=%0d/%h exp=1/%h", count, out, 32'h02000033); end
        pop_one();
    endtask

    task automatic test_timeout();
        send_byte(8'hE0);
        repeat (TIMEOUT - 4) @(negedge clk);
        send_byte(8'h75);
        vectors++; if (out !== 32'h02020075) begin miscompares++; $display("FAIL tmo_not_yet got=%h exp=%h", out, 32'h02020075); end
        pop_one();
        send_byte(8'hE0);
        repeat (TIMEOUT + 1) @(negedge clk);
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL tmo_silent got=%0d exp=0", count); end
        send_byte(8'h75);
        vectors++; if (out !== 32'h02000075) begin miscompares++; $display("FAIL tmo_expired got=%h exp=%h", out, 32'h02000075); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h12);
        send_byte(8'hE0);
        rst = 1'b1;
        #1;
        vectors++; if ({out, out_valid, irq, count, overflow} !== 39'h0) begin miscompares++; $display("FAIL rstmid_outputs got=%h/%b/%b/%0d/%b exp=all 0", out, out_valid, irq, count, overflow); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h1C);
        vectors++; if (out !== 32'h0200001C) begin miscompares++; $display("FAIL rstmid_plain got=%h exp=%h", out, 32'h0200001C); end
        pop_one();
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        rd       = 1'b0;
        clr_ovf  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_make_break();
        test_extended();
        test_modifiers();
        test_pause_and_replies();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
